// File: rtl/emmc_cmd_dev.sv
// emmc_cmd_dev
// Card-end responder for the eMMC CMD line. Receives 48-bit host command
// tokens (start 0, transmission 1, index, argument, CRC7, end 1), verifies
// framing and CRC7, hands good commands to a device-model controller and
// serializes the controller's R1/R3 response after the N_CR gap.
//
// Ports
//   clk_i          CMD-line clock
//   nrst_i         synchronous active-low reset
//   emmc_cmd_i     sampled CMD line (idle high)
//   emmc_cmd_o     CMD drive value (1 when not driving)
//   emmc_cmd_oe_o  CMD output enable
//   cmd_valid_o    one-cycle pulse per good command
//   cmd_idx_o      index of the last good command
//   cmd_arg_o      argument of the last good command
//   cmd_err_o      one-cycle pulse on CRC/framing error
//   rsp_valid_i    controller offers a response
//   rsp_ready_o    high while waiting for the controller's response
//   rsp_type_i     00 none, 01 R1, 10 R3, 11 none
//   rsp_arg_i      R1 card status / R3 OCR
//   busy_o         FSM not idle
module emmc_cmd_dev #(
   parameter int NCR = 2
) (
   input  logic        clk_i,
   input  logic        nrst_i,
   input  logic        emmc_cmd_i,
   output logic        emmc_cmd_o,
   output logic        emmc_cmd_oe_o,
   output logic        cmd_valid_o,
   output logic [5:0]  cmd_idx_o,
   output logic [31:0] cmd_arg_o,
   output logic        cmd_err_o,
   input  logic        rsp_valid_i,
   output logic        rsp_ready_o,
   input  logic [1:0]  rsp_type_i,
   input  logic [31:0] rsp_arg_i,
   output logic        busy_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RX   = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_TX   = 2'd3;

   localparam logic [6:0] NCR_C   = 7'(NCR);
   localparam logic [6:0] GAP_MAX = 7'd127;

   // One serial CRC7 step, polynomial x^7 + x^3 + 1.
   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
      logic fb;
      fb = bit_in ^ crc[6];
      return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   // CRC7 over a 40-bit header+argument field, MSB first, initial value 0.
   function automatic logic [6:0] crc7_40(input logic [39:0] data);
      logic [6:0] crc;
      crc = 7'h00;
      for (int i = 39; i >= 0; i--) begin
         crc = crc7_step(crc, data[i]);
      end
      return crc;
   endfunction

   logic [1:0]  state_q,   state_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [45:0] shift_q,   shift_d;
   logic [6:0]  crc_q,     crc_d;
   logic [6:0]  gap_q,     gap_d;
   logic [47:0] frame_q,   frame_d;
   logic [5:0]  tx_cnt_q,  tx_cnt_d;
   logic        cmd_o_q,   cmd_o_d;
   logic        oe_q,      oe_d;
   logic        valid_q,   valid_d;
   logic        err_q,     err_d;
   logic        ready_q,   ready_d;
   logic        busy_q,    busy_d;
   logic [5:0]  idx_q,     idx_d;
   logic [31:0] arg_q,     arg_d;

   logic        rx_ok_s;
   logic [6:0]  gap_inc_s;
   logic [47:0] r1_frame_s;
   logic [47:0] r3_frame_s;

   // shift_q holds token bits 1..46 at edge E: [45] transmission bit,
   // [44:39] index, [38:7] argument, [6:0] received CRC; the end bit is live.
   assign rx_ok_s    = shift_q[45] & (shift_q[6:0] == crc_q) & emmc_cmd_i;
   assign gap_inc_s  = (gap_q != GAP_MAX) ? (gap_q + 7'd1) : gap_q;
   assign r1_frame_s = {2'b00, idx_q, rsp_arg_i, crc7_40({2'b00, idx_q, rsp_arg_i}), 1'b1};
   assign r3_frame_s = {2'b00, 6'h3F, rsp_arg_i, 7'h7F, 1'b1};

   // Next-state logic for the receive / wait / transmit sequencer.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      crc_d     = crc_q;
      gap_d     = gap_q;
      frame_d   = frame_q;
      tx_cnt_d  = tx_cnt_q;
      cmd_o_d   = cmd_o_q;
      oe_d      = oe_q;
      idx_d     = idx_q;
      arg_d     = arg_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!emmc_cmd_i) begin
               state_d   = S_RX;
               bit_cnt_d = 6'd1;
               crc_d     = 7'h00;
               shift_d   = 46'd0;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_RX: begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            // The start bit (0) leaves a zero CRC unchanged, so bits 1..39 suffice.
            if (bit_cnt_q <= 6'd39) begin
               crc_d = crc7_step(crc_q, emmc_cmd_i);
            end else begin
               crc_d = crc_q;
            end
            if (bit_cnt_q == 6'd47) begin
               if (rx_ok_s) begin
                  valid_d = 1'b1;
                  idx_d   = shift_q[44:39];
                  arg_d   = shift_q[38:7];
                  gap_d   = 7'd1;
                  state_d = S_WAIT;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               shift_d = {shift_q[44:0], emmc_cmd_i};
            end
         end

         S_WAIT: begin
            gap_d = gap_inc_s;
            // A new host start bit wins over a response offered at the same edge.
            if (!emmc_cmd_i) begin
               state_d   = S_RX;
               bit_cnt_d = 6'd1;
               crc_d     = 7'h00;
               shift_d   = 46'd0;
            end else if (rsp_valid_i) begin
               tx_cnt_d = 6'd0;
               case (rsp_type_i)
                  2'b01: begin
                     frame_d = r1_frame_s;
                     state_d = S_TX;
                  end
                  2'b10: begin
                     frame_d = r3_frame_s;
                     state_d = S_TX;
                  end
                  default: begin
                     state_d = S_IDLE;
                  end
               endcase
            end else begin
               state_d = S_WAIT;
            end
         end

         S_TX: begin
            gap_d = gap_inc_s;
            if (!oe_q) begin
               // Hold off until N_CR edges have elapsed since the end bit.
               if (gap_q >= NCR_C) begin
                  oe_d     = 1'b1;
                  cmd_o_d  = frame_q[47];
                  frame_d  = {frame_q[46:0], 1'b1};
                  tx_cnt_d = 6'd1;
               end else begin
                  oe_d = 1'b0;
               end
            end else if (tx_cnt_q == 6'd48) begin
               oe_d    = 1'b0;
               cmd_o_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               cmd_o_d  = frame_q[47];
               frame_d  = {frame_q[46:0], 1'b1};
               tx_cnt_d = tx_cnt_q + 6'd1;
            end
         end

         default: begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
            cmd_o_d = 1'b1;
         end
      endcase

      ready_d = (state_d == S_WAIT);
      busy_d  = (state_d != S_IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!nrst_i) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= 6'd0;
         shift_q   <= 46'd0;
         crc_q     <= 7'h00;
         gap_q     <= 7'd0;
         frame_q   <= 48'd0;
         tx_cnt_q  <= 6'd0;
         cmd_o_q   <= 1'b1;
         oe_q      <= 1'b0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         idx_q     <= 6'd0;
         arg_q     <= 32'd0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         crc_q     <= crc_d;
         gap_q     <= gap_d;
         frame_q   <= frame_d;
         tx_cnt_q  <= tx_cnt_d;
         cmd_o_q   <= cmd_o_d;
         oe_q      <= oe_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         idx_q     <= idx_d;
         arg_q     <= arg_d;
      end
   end

   assign emmc_cmd_o    = cmd_o_q;
   assign emmc_cmd_oe_o = oe_q;
   assign cmd_valid_o   = valid_q;
   assign cmd_err_o     = err_q;
   assign rsp_ready_o   = ready_q;
   assign busy_o        = busy_q;
   assign cmd_idx_o     = idx_q;
   assign cmd_arg_o     = arg_q;

endmodule

// File: tb/tb_emmc_cmd_dev.sv
// Scoreboard bench for emmc_cmd_dev: two instances (NCR=2 and NCR=64),
// directed host tokens, expected events queued by the stimulus and consumed
// by per-instance monitors on the falling clock edge.
module tb_emmc_cmd_dev;

   logic        clk = 1'b0;
   logic        nrst;
   logic        host_cmd [2];
   logic        rsp_valid;
   logic [1:0]  rsp_type;
   logic [31:0] rsp_arg;
   logic        emmc_o [2];
   logic        oe     [2];
   logic        valid  [2];
   logic        err    [2];
   logic        ready  [2];
   logic        busy   [2];
   logic [5:0]  idx    [2];
   logic [31:0] arg    [2];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int          dut;
      int          kind;   // 0 good command, 1 error
      logic [5:0]  idx;
      logic [31:0] arg;
   } ev_t;

   typedef struct {
      int          dut;
      logic [47:0] frame;
      int          offset; // start-bit edge minus edge E
      int          len;    // bits expected on the line
   } rs_t;

   ev_t         evq[$];
   rs_t         rsq[$];
   logic [5:0]  held_idx [2];
   logic [31:0] held_arg [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   emmc_cmd_dev #(.NCR(2)) dut (
      .clk_i(clk), .nrst_i(nrst), .emmc_cmd_i(host_cmd[0]),
      .emmc_cmd_o(emmc_o[0]), .emmc_cmd_oe_o(oe[0]),
      .cmd_valid_o(valid[0]), .cmd_idx_o(idx[0]), .cmd_arg_o(arg[0]),
      .cmd_err_o(err[0]), .rsp_valid_i(rsp_valid), .rsp_ready_o(ready[0]),
      .rsp_type_i(rsp_type), .rsp_arg_i(rsp_arg), .busy_o(busy[0])
   );

   emmc_cmd_dev #(.NCR(64)) dut64 (
      .clk_i(clk), .nrst_i(nrst), .emmc_cmd_i(host_cmd[1]),
      .emmc_cmd_o(emmc_o[1]), .emmc_cmd_oe_o(oe[1]),
      .cmd_valid_o(valid[1]), .cmd_idx_o(idx[1]), .cmd_arg_o(arg[1]),
      .cmd_err_o(err[1]), .rsp_valid_i(rsp_valid), .rsp_ready_o(ready[1]),
      .rsp_type_i(rsp_type), .rsp_arg_i(rsp_arg), .busy_o(busy[1])
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = 7'h00;
      for (int i = 39; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   function automatic logic [47:0] tok(input logic [1:0] hdr, input logic [5:0] i, input logic [31:0] a);
      logic [39:0] b;
      b = {hdr, i, a};
      return {b, crc7(b), 1'b1};
   endfunction

   task automatic push_valid(input int d, input logic [5:0] i, input logic [31:0] a);
      ev_t e;
      e.dut = d; e.kind = 0; e.idx = i; e.arg = a;
      evq.push_back(e);
      held_idx[d] = i;
      held_arg[d] = a;
   endtask

   task automatic push_err(input int d);
      ev_t e;
      e.dut = d; e.kind = 1; e.idx = held_idx[d]; e.arg = held_arg[d];
      evq.push_back(e);
   endtask

   task automatic push_rsp(input int d, input logic [47:0] f, input int off, input int len);
      rs_t r;
      r.dut = d; r.frame = f; r.offset = off; r.len = len;
      rsq.push_back(r);
   endtask

   // Host drives one bit per falling edge; the DUT samples on the rising edge.
   task automatic send(input int d, input logic [47:0] t);
      for (int i = 47; i >= 0; i--) begin
         @(negedge clk);
         host_cmd[d] = t[i];
         if (i == 46) begin
            chk("busy_at_start_bit", 64'(busy[d]), 64'd1);
            chk("ready_low_in_rx", 64'(ready[d]), 64'd0);
         end
      end
   endtask

   // Release the line; returns at the falling edge after edge E.
   task automatic idle(input int d);
      @(negedge clk);
      host_cmd[d] = 1'b1;
   endtask

   // Offer a response so that it is accepted at edge E+k (called right after idle).
   task automatic respond(input int d, input logic [1:0] ty, input logic [31:0] a, input int k);
      repeat (k - 1) @(negedge clk);
      chk("ready_before_accept", 64'(ready[d]), 64'd1);
      rsp_valid = 1'b1; rsp_type = ty; rsp_arg = a;
      @(negedge clk);
      rsp_valid = 1'b0; rsp_type = 2'b00; rsp_arg = 32'd0;
      chk("ready_drop_at_accept", 64'(ready[d]), 64'd0);
      if (ty == 2'b00 || ty == 2'b11) chk("busy_after_none", 64'(busy[d]), 64'd0);
      else chk("busy_in_tx", 64'(busy[d]), 64'd1);
   endtask

   task automatic monitor(input int d);
      bit          col_on;
      int          n;
      int          start;
      int          last_e;
      int          k;
      logic [47:0] col;
      ev_t         e;
      rs_t         r;
      col_on = 1'b0; n = 0; start = 0; last_e = 0; col = 48'd0;
      forever begin
         @(negedge clk);
         if (valid[d] === 1'b1 || err[d] === 1'b1) begin
            k = -1;
            for (int i = 0; i < evq.size(); i++) if (evq[i].dut == d && k < 0) k = i;
            chk("event_expected", 64'(k >= 0), 64'd1);
            if (k >= 0) begin
               e = evq[k];
               evq.delete(k);
               chk("event_kind", 64'(err[d]), 64'(e.kind));
               chk("cmd_idx", 64'(idx[d]), 64'(e.idx));
               chk("cmd_arg", 64'(arg[d]), 64'(e.arg));
               if (e.kind == 0) begin
                  chk("ready_after_valid", 64'(ready[d]), 64'd1);
                  chk("busy_after_valid", 64'(busy[d]), 64'd1);
                  last_e = cyc;
               end else begin
                  chk("no_valid_on_err", 64'(valid[d]), 64'd0);
                  chk("ready_after_err", 64'(ready[d]), 64'd0);
                  chk("busy_after_err", 64'(busy[d]), 64'd0);
               end
            end
         end
         if (oe[d] === 1'b1) begin
            if (!col_on) begin
               col_on = 1'b1; n = 0; col = 48'd0; start = cyc;
            end
            n++;
            col = {col[46:0], emmc_o[d]};
         end else if (col_on) begin
            col_on = 1'b0;
            k = -1;
            for (int i = 0; i < rsq.size(); i++) if (rsq[i].dut == d && k < 0) k = i;
            chk("response_expected", 64'(k >= 0), 64'd1);
            if (k >= 0) begin
               r = rsq[k];
               rsq.delete(k);
               chk("drive_length", 64'(n), 64'(r.len));
               if (n <= 48) chk("response_frame", 64'(col), 64'(r.frame >> (48 - n)));
               chk("response_start_offset", 64'(start - last_e), 64'(r.offset));
               chk("line_released_high", 64'(emmc_o[d]), 64'd1);
            end
         end
      end
   endtask

   initial monitor(0);
   initial monitor(1);

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [47:0] t;
      nrst = 1'b0;
      host_cmd[0] = 1'b1; host_cmd[1] = 1'b1;
      rsp_valid = 1'b0; rsp_type = 2'b00; rsp_arg = 32'd0;
      for (int d = 0; d < 2; d++) begin
         held_idx[d] = 6'd0;
         held_arg[d] = 32'd0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_cmd_o", 64'(emmc_o[d]), 64'd1);
         chk("rst_oe", 64'(oe[d]), 64'd0);
         chk("rst_valid", 64'(valid[d]), 64'd0);
         chk("rst_err", 64'(err[d]), 64'd0);
         chk("rst_ready", 64'(ready[d]), 64'd0);
         chk("rst_busy", 64'(busy[d]), 64'd0);
         chk("rst_idx", 64'(idx[d]), 64'd0);
         chk("rst_arg", 64'(arg[d]), 64'd0);
      end
      nrst = 1'b1;
      repeat (2) @(negedge clk);

      // CMD0, response type none
      push_valid(0, 6'd0, 32'd0);
      send(0, 48'h40_0000_0000_95);
      idle(0);
      respond(0, 2'b00, 32'd0, 1);
      repeat (4) @(negedge clk);

      // CMD17, R1 with status 0x900, accepted at E+1 -> start at E+2
      push_valid(0, 6'd17, 32'd0);
      send(0, 48'h51_0000_0000_55);
      idle(0);
      push_rsp(0, tok(2'b00, 6'd17, 32'h0000_0900), 2, 48);
      respond(0, 2'b01, 32'h0000_0900, 1);
      repeat (60) @(negedge clk);

      // CMD8 corruptions back-to-back, then the good CMD8 with no gap
      t = 48'h48_0000_01AA_87;
      t[12] = ~t[12];
      push_err(0);
      send(0, t);
      t = 48'h48_0000_01AA_87;
      t[0] = 1'b0;
      push_err(0);
      send(0, t);
      push_err(0);
      send(0, tok(2'b00, 6'd8, 32'h0000_01AA));
      push_valid(0, 6'd8, 32'h0000_01AA);
      send(0, 48'h48_0000_01AA_87);
      idle(0);
      respond(0, 2'b00, 32'd0, 1);
      repeat (4) @(negedge clk);

      // CMD1, late R3 accepted at E+10 -> start at E+11
      push_valid(0, 6'd1, 32'h40FF_8080);
      send(0, tok(2'b01, 6'd1, 32'h40FF_8080));
      idle(0);
      push_rsp(0, 48'h3F_40FF_8080_FF, 11, 48);
      respond(0, 2'b10, 32'h40FF_8080, 10);
      repeat (60) @(negedge clk);

      // Preemption: CMD17 left pending, CMD0 arrives
      push_valid(0, 6'd17, 32'd0);
      send(0, 48'h51_0000_0000_55);
      idle(0);
      repeat (3) @(negedge clk);
      push_valid(0, 6'd0, 32'd0);
      send(0, 48'h40_0000_0000_95);
      idle(0);
      respond(0, 2'b00, 32'd0, 1);
      repeat (4) @(negedge clk);

      // Reset during TX at bit 20 (start at E+2, reset edge E+22)
      push_valid(0, 6'd17, 32'd0);
      send(0, 48'h51_0000_0000_55);
      idle(0);
      push_rsp(0, tok(2'b00, 6'd17, 32'h0000_0900), 2, 20);
      respond(0, 2'b01, 32'h0000_0900, 1);
      repeat (20) @(negedge clk);
      nrst = 1'b0;
      @(negedge clk);
      chk("midtx_rst_oe", 64'(oe[0]), 64'd0);
      chk("midtx_rst_cmd_o", 64'(emmc_o[0]), 64'd1);
      chk("midtx_rst_busy", 64'(busy[0]), 64'd0);
      chk("midtx_rst_idx", 64'(idx[0]), 64'd0);
      nrst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         held_idx[d] = 6'd0;
         held_arg[d] = 32'd0;
      end
      repeat (2) @(negedge clk);
      push_valid(0, 6'd8, 32'h0000_01AA);
      send(0, 48'h48_0000_01AA_87);
      idle(0);
      respond(0, 2'b11, 32'h1234_5678, 1);
      repeat (4) @(negedge clk);

      // NCR=64 instance: back-to-back CMD0/CMD17, R1 accepted at E+1 -> start at E+64
      push_valid(1, 6'd0, 32'd0);
      send(1, 48'h40_0000_0000_95);
      push_valid(1, 6'd17, 32'd0);
      send(1, 48'h51_0000_0000_55);
      idle(1);
      push_rsp(1, tok(2'b00, 6'd17, 32'hA5A5_0900), 64, 48);
      respond(1, 2'b01, 32'hA5A5_0900, 1);
      repeat (130) @(negedge clk);

      chk("events_pending", 64'(evq.size()), 64'd0);
      chk("responses_pending", 64'(rsq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/emmc_cmd_dev.md
# emmc_cmd_dev

Device-side (card-end) responder for the eMMC CMD line. It deserializes 48-bit command tokens driven by the host, checks framing and CRC7, and hands each valid command to a device-model controller. It then serializes the controller's R1/R3 response back onto the shared CMD line after the JEDEC N_CR gap. It sits opposite `emmc_sm` in simulation benches and loopback test cores.

## Interface
- `NCR`, default 2: edges from end-bit sample to response start bit; legal range 2..64.
- `clk_i`, in, 1: CMD-line clock (the card clock driven on the pad).
- `nrst_i`, in, 1: synchronous, active-low reset.
- `emmc_cmd_i`, in, 1: sampled CMD line; idle high.
- `emmc_cmd_o`, out, 1: CMD drive value; 1 when not driving.
- `emmc_cmd_oe_o`, out, 1: CMD output enable.
- `cmd_valid_o`, out, 1: one-cycle pulse when a good command is received.
- `cmd_idx_o`, out, 6: command index; held until the next good command.
- `cmd_arg_o`, out, 32: command argument; held until the next good command.
- `cmd_err_o`, out, 1: one-cycle pulse on a CRC or framing error.
- `rsp_valid_i`, in, 1: controller offers a response.
- `rsp_ready_o`, out, 1: high only in WAIT_RSP; the transfer occurs on `rsp_valid_i & rsp_ready_o`.
- `rsp_type_i`, in, 2: 00 none, 01 R1, 10 R3, 11 treated as none.
- `rsp_arg_i`, in, 32: R1 card status or R3 OCR.
- `busy_o`, out, 1: FSM not in IDLE.

## Operation
- **Command token, MSB first:** start 0, transmission 1, index[5:0], arg[31:0], CRC7, end 1.
- **CRC7:** polynomial x^7+x^3+1, initial value 0, computed serially over the first 40 bits.
- **FSM states:** IDLE, RX, WAIT_RSP, TX.
  - IDLE: a 0 sampled on `emmc_cmd_i` moves to RX. Bit count 1 = the start bit.
  - RX: shift bits 1..47; update the CRC on bits 1..39.
  - At the edge sampling bit 47 (edge E), evaluate all three checks: transmission bit = 1, received CRC = computed CRC, end bit = 1.
    - All pass: register `cmd_idx_o`/`cmd_arg_o`, pulse `cmd_valid_o`, go to WAIT_RSP.
    - Otherwise: pulse `cmd_err_o`, go to IDLE. The idx/arg outputs are unchanged.
  - WAIT_RSP: `rsp_ready_o` = 1; wait indefinitely.
    - Accept with type none/11: go to IDLE, nothing is driven.
    - Accept with R1/R3: build a 48-bit frame, then go to TX.
    - A 0 sampled on `emmc_cmd_i` (new host command) preempts: go to RX with bit count 1, no response pending.
- **R1 frame:** 0, 0, `cmd_idx_o`, `rsp_arg_i`, CRC7 over the first 40 bits, 1.
- **R3 frame:** 0, 0, 6'b111111, `rsp_arg_i`, 7'b1111111, 1.
- **TX:** drive 48 bits MSB first with `emmc_cmd_oe_o` = 1. `emmc_cmd_i` is ignored. After bit 47, go to IDLE.
- **Reset (nrst_i low at an edge):** aborts any state, including mid-TX. Outputs return to reset values at that edge.

## Timing
- **Reset values:** `emmc_cmd_o`=1, `emmc_cmd_oe_o`=0, `cmd_valid_o`=0, `cmd_err_o`=0, `rsp_ready_o`=0, `busy_o`=0, `cmd_idx_o`=0, `cmd_arg_o`=0.
- **All outputs are registered.** `cmd_valid_o`/`cmd_err_o` are high for exactly the cycle after edge E. `rsp_ready_o` rises at edge E, so the earliest acceptance is edge E+1.
- **Gap counter:** starts at edge E and keeps counting while the FSM waits.
  - Accept at edge A ≤ E+NCR−1: the start bit is driven from edge E+NCR.
  - Otherwise: the start bit is driven from edge A+1.
  - `rsp_ready_o` drops at edge A.
- **Drive window:** `emmc_cmd_oe_o` is high for exactly 48 cycles and drops at the edge after the end bit is driven.
- **`busy_o` / IDLE return:** `busy_o` rises at the edge sampling the start bit. It falls when the FSM re-enters IDLE:
  - at edge E on an error;
  - at edge A for type none;
  - at the oe-drop edge after TX.
- **Back-to-back commands:** a new start bit is accepted at the first edge in IDLE. There is no dead cycle.

## Test plan
1. **CMD0.** Host sends 0x40_00000000_95 (48 bits). Required: `cmd_valid_o` pulse, idx=0, arg=0. Accept type none at E+1. No CMD drive; `busy_o` low at E+1.
2. **CMD17, R1.** Host sends 0x51_00000000_55. Required: idx=17, arg=0. Accept R1 with status 0x00000900 at E+1. With NCR=2, start bit at edge E+2 and oe high for 48 cycles. Frame = 0x11_00000900 + CRC7 (checked against the bench model) + end 1.
3. **CRC corruption.** CMD8 0x48_000001AA_87 with one argument bit flipped. Required: `cmd_err_o` pulse at E, no `cmd_valid_o`, idx/arg keep their prior values, `rsp_ready_o` stays 0. Repeat with end bit = 0 and with transmission bit = 0.
4. **Late R3.** CMD1 received, R3 arg 0x40FF8080 accepted at E+10. Required: start bit at E+11. Frame = 0x3F_40FF8080_FF.
5. **Preemption and reset.**
   - In WAIT_RSP, the host sends CMD0. Required: the first command is dropped and a valid pulse appears for CMD0.
   - `nrst_i` asserted at TX bit 20. Required: oe=0 and `emmc_cmd_o`=1 after that edge; the next command is decoded normally.
6. **Back-to-back and max NCR.** Two commands with no idle gap, NCR=64. Required: both decoded. Response start exactly at E+64 when accepted at E+1.
